// File: rtl/fetch_sequencer_pkg.sv
// Purpose: shared FSM state encoding and fetch constants for the fetch sequencer.
// Latency: none; this file holds definitions only.
// Backpressure: none; this file holds definitions only.
package fetch_sequencer_pkg;

    // Fetch FSM states.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,  // leaving reset
        S_REQ  = 3'd1,  // presenting a request to imem
        S_WAIT = 3'd2,  // one request outstanding, response will be kept
        S_FULL = 3'd3,  // instruction buffer full, no request presented
        S_DROP = 3'd4   // one request outstanding, response will be thrown away
    } fetch_state_e;

    localparam int INST_W = 32;  // instruction word width
    localparam int PC_INC = 4;   // sequential PC step

endpackage

// File: rtl/fetch_sequencer_buffer.sv
// Purpose: synchronous instruction FIFO ({pc, instruction}) with flush; the head is shown combinationally.
// Latency: an entry pushed at edge N is visible at the head after edge N; head data is unregistered.
// Backpressure: a push into a full FIFO is accepted only alongside a pop; flush wins over push/pop.
//
// Ports: clk, reset (async active-low), flush, push/push_dat, pop, head_dat, full, empty, count.
// While empty, head_dat holds the last entry that was shown at the head (all zeros after reset).
module fetch_sequencer_buffer #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] last_q, last_d;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = empty ? last_q : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        // Track whatever is at the head so the outputs hold steady once the FIFO drains.
        last_d   = head_dat;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CW'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Purpose: instruction-fetch sequencer; owns the PC, issues one imem request at a time, buffers results for decode.
// Latency: request presented the cycle after REQ entry; inst_valid rises memory latency + 1 cycle after acceptance.
// Backpressure: inst_ready low fills the buffer, then imem_req_valid drops until decode pops an entry.
//
// Ports: clk, reset (async active-low); pc_branch/select redirect; imem_req_valid/ready/addr request;
// imem_rsp_valid/data response; inst_valid/ready, instruction, inst_pc to decode.
// Optional: define FETCH_PERF_EN to add saturating perf_fetched / perf_redirects counters.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   pc_branch,
    input  logic              select,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] instruction,
    output logic [XLEN-1:0]   inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_redirects
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_e           state_q, state_d;
    logic [XLEN-1:0]        pc_q, pc_d;
    logic                   buf_push;
    logic                   buf_full;
    logic                   buf_empty;
    logic [CNT_W-1:0]       buf_count;
    logic [XLEN+INST_W-1:0] buf_head;
    logic                   inst_pop;
    logic                   unused_branch_lsb;

    assign unused_branch_lsb = ^pc_branch[1:0];
    assign imem_addr  = pc_q;
    assign inst_valid = !buf_empty;
    assign inst_pop   = inst_valid && inst_ready;
    assign {inst_pc, instruction} = buf_head;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        buf_push       = 1'b0;
        imem_req_valid = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    pc_d    = pc_q + XLEN'(PC_INC);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // REQ is only entered with a free slot, so this push always lands.
                if (imem_rsp_valid) begin
                    buf_push = 1'b1;
                    state_d  = ((buf_count == CNT_W'(BUF_DEPTH - 1)) && !inst_pop) ? S_FULL : S_REQ;
                end
            end
            S_FULL: if (inst_pop || !buf_full) state_d = S_REQ;
            S_DROP: if (imem_rsp_valid) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase

        // Redirect overrides everything; the buffer is flushed on the same edge.
        if (select) begin
            pc_d     = {pc_branch[XLEN-1:2], 2'b00};
            buf_push = 1'b0;
            case (state_q)
                // A request accepted alongside the redirect fetches the old path.
                S_REQ:   state_d = imem_req_ready ? S_DROP : S_REQ;
                S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
                // Still waiting for the old response unless it arrives in this very cycle;
                // remaining in DROP after it has arrived would wait forever.
                S_DROP:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // In WAIT the PC has already advanced past the outstanding request.
    fetch_sequencer_buffer #(
        .WIDTH (XLEN + INST_W),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .flush    (select),
        .push     (buf_push),
        .push_dat ({pc_q - XLEN'(PC_INC), imem_rsp_data}),
        .pop      (inst_pop),
        .head_dat (buf_head),
        .full     (buf_full),
        .empty    (buf_empty),
        .count    (buf_count)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_redirects_q, perf_redirects_d;

    always_comb begin
        perf_fetched_d   = perf_fetched_q;
        perf_redirects_d = perf_redirects_q;
        if (buf_push && (perf_fetched_q != '1)) perf_fetched_d = perf_fetched_q + 32'd1;
        if (select && (perf_redirects_q != '1)) perf_redirects_d = perf_redirects_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_q   <= '0;
            perf_redirects_q <= '0;
        end else begin
            perf_fetched_q   <= perf_fetched_d;
            perf_redirects_q <= perf_redirects_d;
        end
    end

    assign perf_fetched   = perf_fetched_q;
    assign perf_redirects = perf_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Purpose: directed bench for fetch_sequencer: per-cycle vector table plus reset/perf sequences.
// Latency: inputs applied just after a falling edge, outputs sampled 1 time unit later.
// Backpressure: memory ready/response and decode ready are driven directly from the vectors.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc_branch;
    logic        select;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [63:0] inst_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_redirects;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .pc_branch      (pc_branch),
        .select         (select),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .instruction    (instruction),
        .inst_pc        (inst_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_redirects (perf_redirects)
`endif
    );

    typedef struct {
        logic        sel;
        logic [63:0] br;
        logic        rdy;
        logic        rsp;
        logic [31:0] rdat;
        logic        irdy;
        logic        e_rv;
        logic [63:0] e_addr;
        logic        e_iv;
        logic [31:0] e_ins;
        logic [63:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic sel, input logic [63:0] br, input logic rdy, input logic rsp,
                           input logic [31:0] rdat, input logic irdy, input logic e_rv,
                           input logic [63:0] e_addr, input logic e_iv, input logic [31:0] e_ins,
                           input logic [63:0] e_pc);
        vec_t v;
        v.sel = sel; v.br = br; v.rdy = rdy; v.rsp = rsp; v.rdat = rdat; v.irdy = irdy;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_ins = e_ins; v.e_pc = e_pc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic rv, input logic [63:0] a, input logic iv,
                         input logic [31:0] ins, input logic [63:0] pc);
        tests++;
        if (imem_req_valid !== rv || imem_addr !== a || inst_valid !== iv ||
            instruction !== ins || inst_pc !== pc) begin
            fails++;
            $display("FAIL %s: got rv=%0b addr=%h iv=%0b ins=%h pc=%h, want rv=%0b addr=%h iv=%0b ins=%h pc=%h",
                     name, imem_req_valid, imem_addr, inst_valid, instruction, inst_pc, rv, a, iv, ins, pc);
        end
    endtask

    // Starts in REQ at a falling edge; ends at the falling edge after the response is pushed.
    task automatic fetch_one(input logic [31:0] data);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Sequential fetch, 1-cycle memory, decode always ready.
        add_vec(0, 0, 1, 0, 0, 1,             0, 'h0,  0, 0, 0);
        add_vec(0, 0, 1, 0, 0, 1,             1, 'h0,  0, 0, 0);
        add_vec(0, 0, 1, 1, 'h10000000, 1,    0, 'h4,  0, 0, 0);
        add_vec(0, 0, 1, 0, 0, 1,             1, 'h4,  1, 'h10000000, 'h0);
        add_vec(0, 0, 1, 1, 'h10000004, 1,    0, 'h8,  0, 'h10000000, 'h0);
        add_vec(0, 0, 1, 0, 0, 1,             1, 'h8,  1, 'h10000004, 'h4);
        add_vec(0, 0, 1, 1, 'h10000008, 1,    0, 'hC,  0, 'h10000004, 'h4);
        // Decode stalls for 10 cycles: buffer fills to 2, requests stop.
        add_vec(0, 0, 1, 0, 0, 0,             1, 'hC,  1, 'h10000008, 'h8);
        add_vec(0, 0, 1, 1, 'h1000000C, 0,    0, 'h10, 1, 'h10000008, 'h8);
        for (int k = 0; k < 8; k++)
            add_vec(0, 0, 1, 0, 0, 0,         0, 'h10, 1, 'h10000008, 'h8);
        add_vec(0, 0, 1, 0, 0, 1,             0, 'h10, 1, 'h10000008, 'h8);
        add_vec(0, 0, 1, 0, 0, 1,             1, 'h10, 1, 'h1000000C, 'hC);
        add_vec(0, 0, 1, 1, 'h10000010, 1,    0, 'h14, 0, 'h1000000C, 'hC);
        add_vec(0, 0, 1, 0, 0, 1,             1, 'h14, 1, 'h10000010, 'h10);
        // Redirect in WAIT to an unaligned target; stale response dropped.
        add_vec(1, 'h103, 1, 0, 0, 1,         0, 'h18, 0, 'h10000010, 'h10);
        add_vec(0, 0, 1, 1, 'hDEADBEEF, 1,    0, 'h100, 0, 'h10000010, 'h10);
        add_vec(0, 0, 1, 0, 0, 1,             1, 'h100, 0, 'h10000010, 'h10);
        add_vec(0, 0, 1, 1, 'h10000100, 1,    0, 'h104, 0, 'h10000010, 'h10);
        add_vec(0, 0, 1, 0, 0, 1,             1, 'h104, 1, 'h10000100, 'h100);
        // Redirect coincident with the response: word not pushed.
        add_vec(1, 'h200, 1, 1, 'h10000104, 1, 0, 'h108, 0, 'h10000100, 'h100);
        // Memory not ready for 5 cycles: address stable.
        for (int k = 0; k < 5; k++)
            add_vec(0, 0, 0, 0, 0, 1,         1, 'h200, 0, 'h10000100, 'h100);
        add_vec(0, 0, 1, 0, 0, 1,             1, 'h200, 0, 'h10000100, 'h100);
        add_vec(0, 0, 1, 0, 0, 1,             0, 'h204, 0, 'h10000100, 'h100);
        add_vec(0, 0, 1, 1, 'h10000200, 1,    0, 'h204, 0, 'h10000100, 'h100);
        // Redirect while a request is accepted: that request goes stale.
        add_vec(1, 'h300, 1, 0, 0, 1,         1, 'h204, 1, 'h10000200, 'h200);
        add_vec(0, 0, 1, 1, 'hBAD00204, 1,    0, 'h300, 0, 'h10000200, 'h200);
        add_vec(0, 0, 1, 0, 0, 1,             1, 'h300, 0, 'h10000200, 'h200);
        add_vec(0, 0, 1, 1, 'h10000300, 1,    0, 'h304, 0, 'h10000200, 'h200);
        // Redirect to the top word: PC wraps to 0.
        add_vec(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 1, 'h304, 1, 'h10000300, 'h300);
        add_vec(0, 0, 1, 0, 0, 1,             1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 'h10000300, 'h300);
        add_vec(0, 0, 1, 1, 'h20000000, 1,    0, 'h0, 0, 'h10000300, 'h300);
        add_vec(0, 0, 0, 0, 0, 1,             1, 'h0, 1, 'h20000000, 64'hFFFF_FFFF_FFFF_FFFC);

        reset = 1'b1;
        pc_branch = '0; select = 1'b0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;
        #1 reset = 1'b0;
        #2 check("reset", 0, 'h0, 0, 0, 0);
`ifdef FETCH_PERF_EN
        tests++;
        if (perf_fetched !== 32'd0 || perf_redirects !== 32'd0) begin
            fails++;
            $display("FAIL perf_reset: got fetched=%0d redirects=%0d, want 0 0", perf_fetched, perf_redirects);
        end
`endif
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            select         = vecs[i].sel;
            pc_branch      = vecs[i].br;
            imem_req_ready = vecs[i].rdy;
            imem_rsp_valid = vecs[i].rsp;
            imem_rsp_data  = vecs[i].rdat;
            inst_ready     = vecs[i].irdy;
            #1 check($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_addr, vecs[i].e_iv,
                     vecs[i].e_ins, vecs[i].e_pc);
            @(negedge clk);
        end

        // Reset asserted while a request is outstanding.
        select = 1'b0; imem_rsp_valid = 1'b0; inst_ready = 1'b1;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        reset = 1'b0;
        #1 check("rst_mid_wait", 0, 'h0, 0, 0, 0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD0004;
        @(negedge clk);
        reset = 1'b1;
        #1 check("post_rst_idle", 0, 'h0, 0, 0, 0);
        @(negedge clk);
        #1 check("late_rsp_ignored", 1, 'h0, 0, 0, 0);
        imem_rsp_valid = 1'b0;

        fetch_one(32'h30000000);
        #1 check("refetch0", 1, 'h4, 1, 'h30000000, 'h0);
        fetch_one(32'h30000004);
        fetch_one(32'h30000008);
        fetch_one(32'h3000000C);
        #1 check("refetch3", 1, 'h10, 1, 'h3000000C, 'hC);
        select = 1'b1;
        pc_branch = 64'h400;
        @(negedge clk);
        select = 1'b0;
        #1 check("redirect_req", 1, 'h400, 0, 'h3000000C, 'hC);
`ifdef FETCH_PERF_EN
        tests++;
        if (perf_fetched !== 32'd4 || perf_redirects !== 32'd1) begin
            fails++;
            $display("FAIL perf_counts: got fetched=%0d redirects=%0d, want 4 1", perf_fetched, perf_redirects);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
